// File: rtl/inv_cipher_if.sv
// Block-transfer bus for the AES inverse cipher.
// Handshake: a transfer happens on a posedge where valid and ready are both 1.
// The source holds valid and its payload stable until that edge; the sink's
// ready never depends combinationally on valid.
// Input side: in_valid/in_ready carry data_in + key.
// Output side: out_valid/out_ready carry data_out.
// dbg_state mirrors the cipher's FSM state register for observation.
interface inv_cipher_if #(parameter int NK = 4);
  logic            in_valid;
  logic            in_ready;
  logic [127:0]    data_in;
  logic [NK*32-1:0] key;
  logic            out_valid;
  logic            out_ready;
  logic [127:0]    data_out;
  logic [2:0]      dbg_state;

  modport master (
    output in_valid, data_in, key, out_ready,
    input  in_ready, out_valid, data_out, dbg_state
  );

  modport slave (
    input  in_valid, data_in, key, out_ready,
    output in_ready, out_valid, data_out, dbg_state
  );
endinterface

// File: rtl/inv_cipher.sv
// Iterative AES inverse cipher: one transform step (AddRoundKey, InvMixColumns,
// InvShiftRows or InvSubBytes) per clock. Round keys are expanded
// combinationally from the latched cipher key and selected by the round counter.
module inv_cipher #(
  parameter int Nk = 4,
  parameter int Nr = 10
) (
  input logic         clk,
  input logic         rst,
  inv_cipher_if.slave bus
);
  localparam int KW = Nk * 32;
  localparam int NW = 4 * (Nr + 1);
  localparam logic [3:0] NR4 = 4'(Nr);

  // Forward S-box, only needed by the key schedule. Byte b at [2047-8b -: 8].
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Inverse S-box used by InvSubBytes, same layout as SBOX.
  localparam logic [2047:0] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
  };

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ARK  = 3'd1,
    IMC  = 3'd2,
    ISR  = 3'd3,
    ISB  = 3'd4,
    DONE = 3'd5
  } state_t;

  state_t          state, state_nxt;
  logic [3:0]      r, r_nxt;
  logic [127:0]    s, s_nxt;
  logic [KW-1:0]   k, k_nxt;
  logic [127:0]    dout, dout_nxt;
  logic            ov, ov_nxt;
  logic [NW*32-1:0] w;
  logic [127:0]    rk;

  function automatic logic [7:0] sbox_lu(input logic [7:0] b);
    return SBOX[2047 - 8 * int'(b) -: 8];
  endfunction

  function automatic logic [7:0] inv_sbox_lu(input logic [7:0] b);
    return INV_SBOX[2047 - 8 * int'(b) -: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] x);
    return {sbox_lu(x[31:24]), sbox_lu(x[23:16]), sbox_lu(x[15:8]), sbox_lu(x[7:0])};
  endfunction

  // Standard AES key schedule; word 0 lands in the most significant bits.
  function automatic logic [NW*32-1:0] key_expand(input logic [KW-1:0] key_v);
    logic [31:0]      wa [NW];
    logic [31:0]      t;
    logic [7:0]       rc;
    logic [NW*32-1:0] flat;
    rc   = 8'h01;
    flat = '0;
    for (int i = 0; i < Nk; i++) wa[i] = key_v[KW-1-32*i -: 32];
    for (int i = Nk; i < NW; i++) begin
      t = wa[i-1];
      if (i % Nk == 0) begin
        t  = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h000000};
        rc = xtime(rc);
      end else if (Nk > 6 && i % Nk == 4) begin
        t = sub_word(t);
      end
      wa[i] = wa[i-Nk] ^ t;
    end
    for (int i = 0; i < NW; i++) flat[NW*32-1-32*i -: 32] = wa[i];
    return flat;
  endfunction

  // One column times circ(0e,0b,0d,09) over GF(2^8).
  function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
    logic [7:0]  a  [4];
    logic [7:0]  x2 [4];
    logic [7:0]  x4 [4];
    logic [7:0]  x8 [4];
    logic [31:0] res;
    res = '0;
    for (int j = 0; j < 4; j++) begin
      a[j]  = col[31-8*j -: 8];
      x2[j] = xtime(a[j]);
      x4[j] = xtime(x2[j]);
      x8[j] = xtime(x4[j]);
    end
    for (int j = 0; j < 4; j++) begin
      res[31-8*j -: 8] = (x8[j]       ^ x4[j]       ^ x2[j])
                       ^ (x8[(j+1)%4] ^ x2[(j+1)%4] ^ a[(j+1)%4])
                       ^ (x8[(j+2)%4] ^ x4[(j+2)%4] ^ a[(j+2)%4])
                       ^ (x8[(j+3)%4] ^ a[(j+3)%4]);
    end
    return res;
  endfunction

  function automatic logic [127:0] inv_mix_columns(input logic [127:0] x);
    logic [127:0] y;
    y = '0;
    for (int c = 0; c < 4; c++) y[127-32*c -: 32] = inv_mix_col(x[127-32*c -: 32]);
    return y;
  endfunction

  // Byte (row rw, column c) sits at index 4c+rw; row rw rotates right by rw.
  function automatic logic [127:0] inv_shift_rows(input logic [127:0] x);
    logic [127:0] y;
    y = '0;
    for (int c = 0; c < 4; c++)
      for (int rw = 0; rw < 4; rw++)
        y[127-8*(4*c+rw) -: 8] = x[127-8*(4*((c-rw+4)%4)+rw) -: 8];
    return y;
  endfunction

  function automatic logic [127:0] inv_sub_bytes(input logic [127:0] x);
    logic [127:0] y;
    y = '0;
    for (int n = 0; n < 16; n++) y[127-8*n -: 8] = inv_sbox_lu(x[127-8*n -: 8]);
    return y;
  endfunction

  assign w  = key_expand(k);
  assign rk = w[NW*32-1 - int'(r)*128 -: 128];

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = ov;
  assign bus.data_out  = dout;
  assign bus.dbg_state = state;

  // State, round counter and datapath registers; reset aborts any block.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      r     <= '0;
      s     <= '0;
      k     <= '0;
      dout  <= '0;
      ov    <= 1'b0;
    end else begin
      state <= state_nxt;
      r     <= r_nxt;
      s     <= s_nxt;
      k     <= k_nxt;
      dout  <= dout_nxt;
      ov    <= ov_nxt;
    end
  end

  // Next-state and datapath step selection, one transform per cycle.
  always_comb begin
    state_nxt = state;
    r_nxt     = r;
    s_nxt     = s;
    k_nxt     = k;
    dout_nxt  = dout;
    ov_nxt    = ov;
    case (state)
      IDLE: begin
        if (bus.in_valid) begin
          s_nxt     = bus.data_in;
          k_nxt     = bus.key;
          r_nxt     = NR4;
          state_nxt = ARK;
        end
      end
      ARK: begin
        s_nxt = s ^ rk;
        if (r == 4'd0) begin
          dout_nxt  = s ^ rk;
          ov_nxt    = 1'b1;
          state_nxt = DONE;
        end else if (r == NR4) begin
          state_nxt = ISR;
        end else begin
          state_nxt = IMC;
        end
      end
      IMC: begin
        s_nxt     = inv_mix_columns(s);
        state_nxt = ISR;
      end
      ISR: begin
        s_nxt     = inv_shift_rows(s);
        state_nxt = ISB;
      end
      ISB: begin
        s_nxt     = inv_sub_bytes(s);
        r_nxt     = r - 4'd1;
        state_nxt = ARK;
      end
      DONE: begin
        if (bus.out_ready) begin
          ov_nxt    = 1'b0;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end
endmodule

// File: tb/tb_inv_cipher.sv
// Bench for inv_cipher: an AES-128 and an AES-256 instance, driven from one
// directed sequence plus random blocks encrypted by a behavioural AES model.
module tb_inv_cipher;
  logic clk;
  logic rst;

  inv_cipher_if #(.NK(4)) b128 ();
  inv_cipher_if #(.NK(8)) b256 ();

  inv_cipher #(.Nk(4), .Nr(10)) dut128 (.clk(clk), .rst(rst), .bus(b128));
  inv_cipher #(.Nk(8), .Nr(14)) dut256 (.clk(clk), .rst(rst), .bus(b256));

  int checks = 0;
  int errors = 0;
  logic [127:0] exp_q[$];
  logic [7:0] sbox [256];

  localparam logic [255:0] K1  = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
  localparam logic [127:0] CT1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] PT1 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [255:0] K2  = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
  localparam logic [127:0] CT2 = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] PT2 = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [255:0] K5  = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] CT5 = 128'h8ea2b7ca516745bfeafc49904b496089;

  // Clock and watchdog
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  // ---------------- reference model ----------------
  function automatic logic [7:0] gmul(logic [7:0] a, logic [7:0] b);
    logic [7:0] p;
    p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl1(logic [7:0] x);
    return {x[6:0], x[7]};
  endfunction

  // S-box from its definition: multiplicative inverse then affine map.
  task automatic build_sbox();
    logic [7:0] inv;
    logic [7:0] a;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      a = inv;
      for (int i = 0; i < 4; i++) begin
        a = rotl1(a);
        inv = inv ^ a;
      end
      sbox[x] = inv ^ 8'h63;
    end
  endtask

  function automatic logic [127:0] model_encrypt(logic [127:0] pt, logic [255:0] key, int nk);
    logic [7:0] w [240];
    logic [7:0] st [16];
    logic [7:0] t [16];
    logic [7:0] tmp [4];
    logic [7:0] t0;
    logic [7:0] rc;
    logic [127:0] res;
    int nr;
    nr = nk + 6;
    rc = 8'h01;
    for (int i = 0; i < 4 * nk; i++) w[i] = key[255-8*i -: 8];
    for (int i = nk; i < 4 * (nr + 1); i++) begin
      for (int j = 0; j < 4; j++) tmp[j] = w[4*(i-1)+j];
      if (i % nk == 0) begin
        t0 = tmp[0]; tmp[0] = tmp[1]; tmp[1] = tmp[2]; tmp[2] = tmp[3]; tmp[3] = t0;
        for (int j = 0; j < 4; j++) tmp[j] = sbox[tmp[j]];
        tmp[0] = tmp[0] ^ rc;
        rc = gmul(rc, 8'h02);
      end else if (nk > 6 && i % nk == 4) begin
        for (int j = 0; j < 4; j++) tmp[j] = sbox[tmp[j]];
      end
      for (int j = 0; j < 4; j++) w[4*i+j] = w[4*(i-nk)+j] ^ tmp[j];
    end
    for (int n = 0; n < 16; n++) st[n] = pt[127-8*n -: 8] ^ w[n];
    for (int rd = 1; rd <= nr; rd++) begin
      for (int n = 0; n < 16; n++) st[n] = sbox[st[n]];
      for (int c = 0; c < 4; c++)
        for (int rw = 0; rw < 4; rw++) t[4*c+rw] = st[4*((c+rw)%4)+rw];
      for (int c = 0; c < 4; c++)
        for (int rw = 0; rw < 4; rw++)
          if (rd != nr)
            st[4*c+rw] = gmul(t[4*c+rw], 8'h02) ^ gmul(t[4*c+(rw+1)%4], 8'h03)
                       ^ t[4*c+(rw+2)%4] ^ t[4*c+(rw+3)%4];
          else
            st[4*c+rw] = t[4*c+rw];
      for (int n = 0; n < 16; n++) st[n] = st[n] ^ w[16*rd+n];
    end
    res = '0;
    for (int n = 0; n < 16; n++) res[127-8*n -: 8] = st[n];
    return res;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // ---------------- check helper ----------------
  task automatic check(string tag, logic [127:0] obs, logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // ---------------- bus accessors ----------------
  function automatic logic get_in_ready(bit wide);
    return wide ? b256.in_ready : b128.in_ready;
  endfunction

  function automatic logic get_out_valid(bit wide);
    return wide ? b256.out_valid : b128.out_valid;
  endfunction

  function automatic logic [127:0] get_data_out(bit wide);
    return wide ? b256.data_out : b128.data_out;
  endfunction

  task automatic set_in(bit wide, logic v, logic [127:0] ct, logic [255:0] key);
    if (wide) begin
      b256.in_valid = v; b256.data_in = ct; b256.key = key;
    end else begin
      b128.in_valid = v; b128.data_in = ct; b128.key = key[255:128];
    end
  endtask

  task automatic set_out_ready(bit wide, logic v);
    if (wide) b256.out_ready = v;
    else      b128.out_ready = v;
  endtask

  // ---------------- driver tasks ----------------
  // Called at a negedge; returns at the negedge after the accept edge.
  task automatic send_block(bit wide, logic [127:0] ct, logic [255:0] key, logic [127:0] exp_pt);
    int n;
    n = 0;
    while (!get_in_ready(wide) && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("send_in_ready", 128'(get_in_ready(wide)), 128'(1));
    set_in(wide, 1'b1, ct, key);
    @(posedge clk);
    @(negedge clk);
    set_in(wide, 1'b0, rand128(), {rand128(), rand128()});
    exp_q.push_back(exp_pt);
  endtask

  // Waits for out_valid, checks latency and plaintext. hold>0 keeps
  // out_ready low that many cycles after out_valid. garble drives random
  // inputs and in_valid pulses while the block is busy.
  task automatic recv_block(bit wide, int exp_lat, int hold, bit garble, string tag);
    int n;
    logic [127:0] e;
    n = 0;
    set_out_ready(wide, hold == 0);
    while (!get_out_valid(wide) && n < 300) begin
      if (garble) begin
        check({tag, "_busy_in_ready"}, 128'(get_in_ready(wide)), 128'(0));
        set_in(wide, 1'($urandom_range(0, 1)), rand128(), {rand128(), rand128()});
      end
      @(negedge clk);
      n++;
    end
    set_in(wide, 1'b0, rand128(), {rand128(), rand128()});
    check({tag, "_latency"}, 128'(n), 128'(exp_lat));
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 128'hx;
    check({tag, "_data_out"}, get_data_out(wide), e);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check({tag, "_hold_out_valid"}, 128'(get_out_valid(wide)), 128'(1));
      check({tag, "_hold_data_out"}, get_data_out(wide), e);
    end
    set_out_ready(wide, 1'b1);
    @(negedge clk);
    if (hold > 0) begin
      check({tag, "_post_out_valid"}, 128'(get_out_valid(wide)), 128'(0));
      check({tag, "_post_in_ready"}, 128'(get_in_ready(wide)), 128'(1));
      check({tag, "_post_data_out"}, get_data_out(wide), e);
    end
  endtask

  // ---------------- directed and random sequence ----------------
  initial begin
    logic [127:0] pt;
    logic [127:0] ct;
    logic [255:0] key;
    logic saw_ov;

    build_sbox();
    rst = 1'b1;
    set_in(1'b0, 1'b0, '0, '0);
    set_in(1'b1, 1'b0, '0, '0);
    b128.out_ready = 1'b1;
    b256.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Reset state
    check("rst_in_ready", 128'(b128.in_ready), 128'(1));
    check("rst_out_valid", 128'(b128.out_valid), 128'(0));
    check("rst_data_out", b128.data_out, 128'h0);
    check("rst256_in_ready", 128'(b256.in_ready), 128'(1));
    check("rst256_out_valid", 128'(b256.out_valid), 128'(0));

    // 1: FIPS-197 AES-128 vector, 40-cycle latency
    send_block(1'b0, CT1, K1, PT1);
    recv_block(1'b0, 40, 0, 1'b0, "t1");

    // 2: out_ready held low 5 cycles
    send_block(1'b0, CT2, K2, PT2);
    recv_block(1'b0, 40, 5, 1'b0, "t2");

    // 3: garbage and in_valid pulses while busy, then a second block
    send_block(1'b0, CT1, K1, PT1);
    recv_block(1'b0, 40, 0, 1'b1, "t3a");
    pt = rand128();
    key = {rand128(), rand128()};
    send_block(1'b0, model_encrypt(pt, key, 4), key, pt);
    recv_block(1'b0, 40, 0, 1'b0, "t3b");

    // 4: reset 20 cycles into a block
    pt = rand128();
    key = {rand128(), rand128()};
    send_block(1'b0, model_encrypt(pt, key, 4), key, pt);
    repeat (20) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    check("t4_in_ready", 128'(b128.in_ready), 128'(1));
    check("t4_out_valid", 128'(b128.out_valid), 128'(0));
    check("t4_data_out", b128.data_out, 128'h0);
    saw_ov = 1'b0;
    repeat (60) begin
      @(negedge clk);
      saw_ov = saw_ov | b128.out_valid;
    end
    check("t4_no_out_valid", 128'(saw_ov), 128'(0));
    send_block(1'b0, CT2, K2, PT2);
    recv_block(1'b0, 40, 0, 1'b0, "t4b");

    // 5: AES-256 vector, 56-cycle latency
    send_block(1'b1, CT5, K5, PT1);
    recv_block(1'b1, 56, 0, 1'b0, "t5");

    // 6: random key/plaintext pairs, back to back
    for (int i = 0; i < 1000; i++) begin
      pt = rand128();
      key = {rand128(), rand128()};
      ct = model_encrypt(pt, key, 4);
      send_block(1'b0, ct, key, pt);
      recv_block(1'b0, 40, 0, 1'b0, "rnd128");
    end
    for (int i = 0; i < 100; i++) begin
      pt = rand128();
      key = {rand128(), rand128()};
      ct = model_encrypt(pt, key, 8);
      send_block(1'b1, ct, key, pt);
      recv_block(1'b1, 56, 0, 1'b0, "rnd256");
    end

    // Final report
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
